// File: rtl/demux32_1x32_wb.sv
// -----------------------------------------------------------------------------
// demux32_1x32_wb
//
// Registered 1-to-32 word distributor on the register-bank write-back path.
// A 32-bit word is steered into one of 32 held 32-bit entries. Four kinds of
// update are supported:
//   - single write to one entry,
//   - burst write with auto-incrementing destination (wraps 31 -> 0),
//   - broadcast write to every entry,
//   - a 32-cycle clear sweep that zeroes entries 0..31 in order.
// A one-hot write strobe reports which entries changed on the previous edge.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
//   ready is combinational. In IDLE it is !clr, so a clear request wins over
//   a simultaneous beat. In BURST it is 1. In CLEAR it is 0. valid may be
//   dropped at any time; a burst simply waits for the next valid beat.
//
// Parameters
//   ZERO_R0   : 1 -> entry 0 is hard-wired to zero and stb[0] never asserts.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   d         : write data
//   s         : destination index / burst start index
//   mode      : 00 single, 01 burst, 10 broadcast, 11 single
//   len       : burst length, 0 means 32
//   valid     : beat offered
//   clr       : clear-sweep request, level-sampled in IDLE
//   ready     : beat accepted on an edge where valid && ready
//   y         : held entries, entry k at y[32k+31:32k]
//   stb       : registered write strobe for the entries updated last edge
//   last      : one-cycle pulse after the final burst beat or clear step
//   busy      : block is not in IDLE
//   dbg_state : current FSM state (0 IDLE, 1 BURST, 2 CLEAR)
// -----------------------------------------------------------------------------
module demux32_1x32_wb #(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   d,
  input  logic [4:0]    s,
  input  logic [1:0]    mode,
  input  logic [4:0]    len,
  input  logic          valid,
  input  logic          clr,
  output logic          ready,
  output logic [1023:0] y,
  output logic [31:0]   stb,
  output logic          last,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [4:0]         ptr, ptr_d;
  logic [4:0]         rem, rem_d;
  logic [31:0][31:0]  ent;
  logic [31:0]        wmask;
  logic [31:0]        wdata;
  logic               last_d;

  // ---------------------------------------------------------------------------
  // Next-state, write mask and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    rem_d   = rem;
    wmask   = '0;
    wdata   = d;
    last_d  = 1'b0;
    ready   = 1'b0;

    case (state)
      ST_IDLE: begin
        ready = !clr;
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = 5'd0;
        end else if (valid) begin
          case (mode)
            2'b10: wmask = '1;
            2'b01: begin
              wmask = 32'd1 << s;
              if (len == 5'd1) begin
                last_d = 1'b1;
              end else begin
                // len == 0 encodes 32 beats; 5-bit wrap of len-1 yields 31.
                ptr_d   = s + 5'd1;
                rem_d   = len - 5'd1;
                state_d = ST_BURST;
              end
            end
            default: wmask = 32'd1 << s;  // 00 and reserved 11
          endcase
        end
      end

      ST_BURST: begin
        ready = 1'b1;
        if (valid) begin
          wmask = 32'd1 << ptr;
          ptr_d = ptr + 5'd1;
          rem_d = rem - 5'd1;
          if (rem == 5'd1) begin
            last_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_CLEAR: begin
        wmask = 32'd1 << ptr;
        wdata = '0;
        ptr_d = ptr + 5'd1;
        if (ptr == 5'd31) begin
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Entry 0 is constant zero when hard-wired; masking here also keeps
    // its strobe bit low for every kind of update.
    if (ZERO_R0) wmask[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State and entry registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 5'd0;
      rem   <= 5'd0;
      ent   <= '0;
      stb   <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      rem   <= rem_d;
      stb   <= wmask;
      last  <= last_d;
      for (int k = 0; k < 32; k++) begin
        if (wmask[k]) ent[k] <= wdata;
      end
    end
  end

  assign y         = ent;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_demux32_1x32_wb.sv
// -----------------------------------------------------------------------------
// tb_demux32_1x32_wb
//
// Drives two instances (ZERO_R0 = 0 and ZERO_R0 = 1) with identical inputs and
// compares both against a reference model built from whole-transaction rules:
// a burst is expanded into a queue of destination indices when it starts, and
// a clear sweep is a countdown of remaining steps.
// -----------------------------------------------------------------------------
module tb_demux32_1x32_wb;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT inputs / outputs
  // ---------------------------------------------------------------------------
  logic [31:0]   d;
  logic [4:0]    s;
  logic [1:0]    mode;
  logic [4:0]    len;
  logic          valid;
  logic          clr;

  logic          ready0, ready1;
  logic [1023:0] y0, y1;
  logic [31:0]   stb0, stb1;
  logic          last0, last1;
  logic          busy0, busy1;
  logic [1:0]    dbg0, dbg1;

  demux32_1x32_wb #(.ZERO_R0(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .len(len),
    .valid(valid), .clr(clr), .ready(ready0), .y(y0), .stb(stb0),
    .last(last0), .busy(busy0), .dbg_state(dbg0)
  );

  demux32_1x32_wb #(.ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .len(len),
    .valid(valid), .clr(clr), .ready(ready1), .y(y1), .stb(stb1),
    .last(last1), .busy(busy1), .dbg_state(dbg1)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] mdl   [2][32];
  logic [31:0] exp_stb [2];
  logic        exp_last;
  int          burst_q[$];   // destinations still owed by an open burst
  int          clear_left;   // clear steps still to run

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard compare
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_dut(input int z, input logic [1023:0] yv, input logic [31:0] sb,
                         input logic lt, input logic by);
    logic exp_busy;
    exp_busy = (clear_left > 0) || (burst_q.size() > 0);
    for (int k = 0; k < 32; k++)
      chk($sformatf("y%0d[%0d]", z, k), yv[32*k +: 32], mdl[z][k]);
    chk($sformatf("stb%0d", z), sb, exp_stb[z]);
    chk($sformatf("last%0d", z), {31'd0, lt}, {31'd0, exp_last});
    chk($sformatf("busy%0d", z), {31'd0, by}, {31'd0, exp_busy});
  endtask

  task automatic chk_all();
    chk_dut(0, y0, stb0, last0, busy0);
    chk_dut(1, y1, stb1, last1, busy1);
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int k = 0; k < 32; k++) mdl[z][k] = '0;
      exp_stb[z] = '0;
    end
    exp_last   = 1'b0;
    burst_q.delete();
    clear_left = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, check ready, advance, check outputs.
  // Called 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic [31:0] dv, input logic [4:0] sv, input logic [1:0] mv,
                      input logic [4:0] lv, input logic vv, input logic cv);
    logic [31:0] w;
    logic [31:0] wd;
    logic [31:0] msk;
    logic        lx;
    logic        er;
    int          a;
    int          n;
    d = dv; s = sv; mode = mv; len = lv; valid = vv; clr = cv;
    w = '0; wd = dv; lx = 1'b0;

    if (clear_left > 0)          er = 1'b0;
    else if (burst_q.size() > 0) er = 1'b1;
    else                         er = !cv;
    #1;
    chk("ready0", {31'd0, ready0}, {31'd0, er});
    chk("ready1", {31'd0, ready1}, {31'd0, er});

    if (clear_left > 0) begin
      a  = 32 - clear_left;
      w  = 32'd1 << a;
      wd = '0;
      clear_left--;
      lx = (clear_left == 0);
    end else if (burst_q.size() > 0) begin
      if (vv) begin
        a  = burst_q.pop_front();
        w  = 32'd1 << a;
        lx = (burst_q.size() == 0);
      end
    end else if (cv) begin
      clear_left = 32;
    end else if (vv) begin
      if (mv == 2'b10) begin
        w = '1;
      end else begin
        w = 32'd1 << sv;
        if (mv == 2'b01) begin
          n = (lv == 5'd0) ? 32 : int'(lv);
          for (int i = 1; i < n; i++) burst_q.push_back((int'(sv) + i) % 32);
          lx = (n == 1);
        end
      end
    end

    for (int z = 0; z < 2; z++) begin
      msk = (z == 1) ? (w & 32'hFFFF_FFFE) : w;
      for (int k = 0; k < 32; k++) if (msk[k]) mdl[z][k] = wd;
      exp_stb[z] = msk;
    end
    exp_last = lx;

    @(posedge clk);
    #1;
    chk_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic reset_now();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    d = '0; s = '0; mode = '0; len = '0; valid = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset_now();
    chk("ready_rst", {31'd0, ready0}, 32'd1);

    // Single write after reset.
    step(32'hDEADBEEF, 5'd5, 2'b00, 5'd0, 1'b1, 1'b0);
    step(32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

    // Wrapping burst 30,31,0,1 with a one-cycle stall mid-burst.
    step(32'd1, 5'd30, 2'b01, 5'd4, 1'b1, 1'b0);
    step(32'd2, 5'd3,  2'b10, 5'd9, 1'b1, 1'b0);
    step(32'd0, 5'd0,  2'b00, 5'd0, 1'b0, 1'b1);  // stall; clr ignored in burst
    step(32'd3, 5'd0,  2'b00, 5'd0, 1'b1, 1'b0);
    step(32'd4, 5'd0,  2'b00, 5'd0, 1'b1, 1'b0);
    step(32'd0, 5'd0,  2'b00, 5'd0, 1'b0, 1'b0);

    // Broadcast.
    step(32'h12345678, 5'd0, 2'b10, 5'd0, 1'b1, 1'b0);

    // Reserved mode 11 acts as single; LEN=1 burst finishes in IDLE.
    step(32'hA5A5A5A5, 5'd9, 2'b11, 5'd0, 1'b1, 1'b0);
    step(32'h5A5A5A5A, 5'd0, 2'b01, 5'd1, 1'b1, 1'b0);
    step(32'h0BADF00D, 5'd17, 2'b01, 5'd1, 1'b1, 1'b0);

    // Clear sweep contending with a beat, then beats offered during it.
    step(32'hFFFF0000, 5'd3, 2'b00, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++)
      step($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'd2, 1'b1, 1'($urandom_range(0, 1)));
    step(32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

    // Burst of 32 starting at 7, back-to-back.
    step(32'h1000, 5'd7, 2'b01, 5'd0, 1'b1, 1'b0);
    for (int i = 1; i < 32; i++)
      step(32'h1000 + i, 5'($urandom_range(0, 31)), 2'b10, 5'd3, 1'b1, 1'b0);
    step(32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

    // Reset at beat 3 of an 8-beat burst, then a normal single write.
    step(32'hB0, 5'd12, 2'b01, 5'd8, 1'b1, 1'b0);
    step(32'hB1, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
    d = 32'hB2; valid = 1'b1;
    reset_now();
    step(32'hC0FFEE02, 5'd2, 2'b00, 5'd0, 1'b1, 1'b0);
    step(32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 6)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux32_1x32_wb.md
# demux32_1x32_wb

Registered 1-to-32 word distributor: the write-side counterpart of the 32-bit 32x1 read multiplexer. It accepts a 32-bit word plus a 5-bit destination and steers it into one of 32 held 32-bit output entries. It supports single, burst (auto-increment) and broadcast writes, plus a sequential clear sweep. It sits on the register-bank write-back path and drives a one-hot write strobe that downstream logic uses to track which entry changed.

## Interface
- ZERO_R0, default 1: when 1, entry 0 is never written, always reads 0, and STB[0] never asserts.
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- D  input  32  write data.
- S  input  5  destination index; burst start index.
- MODE  input  2  00 single, 01 burst, 10 broadcast, 11 treated as single. Sampled only on an accepted beat in IDLE.
- LEN  input  5  burst length; 0 means 32. Sampled with the burst-start beat.
- VALID  input  1  beat offered.
- CLR  input  1  request clear sweep. Level-sampled in IDLE.
- READY  output  1  beat accepted on the edge where VALID&READY.
- Y  output  1024  held entries; entry k occupies Y[32k+31:32k].
- STB  output  32  registered write strobe for entries updated on the previous edge.
- LAST  output  1  one-cycle pulse after the final burst beat or the final clear step.
- BUSY  output  1  state != IDLE.

## Operation
- States: IDLE, BURST, CLEAR. Reset puts the block in IDLE.
- READY is combinational:
  - IDLE: READY = !CLR.
  - BURST: READY = 1.
  - CLEAR: READY = 0.
- IDLE, CLR=1: enter CLEAR and set ptr=0. VALID is ignored, so CLR wins over a simultaneous beat.
- IDLE, accepted beat:
  - Single: entry[S]=D.
  - Broadcast: all entries=D.
  - Burst: entry[S]=D. If LEN==1, stay IDLE and pulse LAST. Otherwise set ptr=S+1 mod 32, rem=LEN-1 (LEN=0 gives rem=31), and enter BURST.
- BURST, accepted beat: entry[ptr]=D, ptr=ptr+1 mod 32 (31 wraps to 0), rem=rem-1.
  - When the beat with rem==1 is accepted, pulse LAST and return to IDLE.
  - VALID low stalls the burst indefinitely.
  - MODE, S, LEN and CLR are ignored in BURST.
- CLEAR: each cycle entry[ptr]=0 and ptr increments. After ptr==31 is cleared, pulse LAST and return to IDLE. The sweep takes exactly 32 cycles.
- ZERO_R0=1: any write or clear targeting entry 0 is suppressed, and its STB bit stays 0. Broadcast writes entries 1..31 only.
- Unselected entries hold their value.

## Timing
- Reset (RST low, asynchronous): Y=0, STB=0, LAST=0, state IDLE, ptr=0, rem=0. READY reads !CLR.
- Write latency:
  - Entry updates on the accepting rising edge.
  - STB and LAST are registered and assert for exactly the one cycle after that edge, aligned with the new Y.
- STB patterns:
  - Single or burst beat: one-hot.
  - Broadcast: 0xFFFFFFFF, or 0xFFFFFFFE when ZERO_R0=1.
  - Clear: one-hot per step.
  - No update that cycle: 0.
- Back-to-back throughput: one beat per cycle in IDLE and BURST with no bubbles. A new single/burst/broadcast or CLR may be accepted on the cycle immediately after LAST is set.
- RST asserted mid-burst or mid-clear: immediate return to IDLE with all entries 0. The remaining beats are abandoned.
- Illegal or reserved MODE=11 behaves as single. No X may propagate from an unused MODE.

## Test plan
- Reset then single: RST low, then high; D=0xDEADBEEF, S=5, MODE=00, VALID=1 for one cycle. Next cycle: Y entry5=0xDEADBEEF, STB=0x00000020, all other entries 0, LAST=0.
- Wrapping burst: S=30, LEN=4, MODE=01, data 1,2,3,4 on consecutive cycles, with VALID low for one cycle mid-burst. Entries 30,31,0,1 get 1,2,3,4 (ZERO_R0=0). BUSY stays high through the stall. LAST pulses once after beat 4. READY=1 throughout.
- ZERO_R0=1 broadcast: D=0x12345678, MODE=10. Entries 1..31=0x12345678, entry 0=0, STB=0xFFFFFFFE.
- Clear sweep with contention: after filling entries, assert CLR together with VALID in IDLE. Beat not accepted (READY=0). 32 cycles of one-hot STB from bit 0 to bit 31. LAST after the final step. All entries 0. BUSY low on the following cycle.
- Burst of 32: LEN=0, S=7. 32 beats fill every entry with no wrap overwrite; LAST pulses after exactly the 32nd beat.
- Reset mid-operation: pull RST low at beat 3 of a LEN=8 burst. Y=0, STB=0, BUSY=0 immediately. After release, a single write to S=2 works normally.
